// File: rtl/wr_commit_pkg.sv
// Shared types for the golden-vs-pipelined write commit checker.
// Default widths, queue entry layout, checker FSM states and PENDING width helper.
package wr_commit_pkg;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int DEPTH_DEF = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    typedef enum logic {
        CHECK = 1'b0,
        HALT  = 1'b1
    } chk_state_t;

    function automatic int pend_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PEND_W = pend_width(DEPTH_DEF);
endpackage

// File: rtl/wr_commit_fifo.sv
// Golden-write queue: power-of-two ring buffer with occupancy count, async reset and sync clear.
// Registered pointers/count, head visible combinationally; push while full is accepted only with a same-cycle pop.
module wr_commit_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdat,
    output logic [WIDTH-1:0]         rdat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == FULL_CNT);
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdat    = mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdat;
    end
endmodule

// File: rtl/wr_commit_checker.sv
// Lockstep checker: queues golden writes, compares each pipelined write against the oldest; first-mismatch capture under WR_COMMIT_CHECKER_CAPTURE_EN.
// All outputs registered (one-edge latency); no backpressure, drops golden writes on overflow and halts on commit timeout.
module wr_commit_checker
    import wr_commit_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          CLEAR,
    input  logic                          GOLD_WE,
    input  logic [ADDR_WIDTH-1:0]         GOLD_ADDR,
    input  logic [DATA_WIDTH-1:0]         GOLD_DATA,
    input  logic                          DUT_WE,
    input  logic [ADDR_WIDTH-1:0]         DUT_ADDR,
    input  logic [DATA_WIDTH-1:0]         DUT_DATA,
    output logic [CNT_WIDTH-1:0]          MATCH_CNT,
    output logic [CNT_WIDTH-1:0]          ERR_CNT,
    output logic                          MISMATCH,
    output logic                          UNEXPECTED,
    output logic                          OVERFLOW,
    output logic                          TIMEOUT_ERR,
    output logic [pend_width(DEPTH)-1:0]  PENDING
`ifdef WR_COMMIT_CHECKER_CAPTURE_EN
    ,
    output logic [ADDR_WIDTH-1:0]         FAIL_ADDR_EXP,
    output logic [ADDR_WIDTH-1:0]         FAIL_ADDR_GOT,
    output logic [DATA_WIDTH-1:0]         FAIL_DATA_EXP,
    output logic [DATA_WIDTH-1:0]         FAIL_DATA_GOT,
    output logic [CNT_WIDTH-1:0]          FAIL_INDEX
`endif
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIM = TIMEOUT[TW-1:0];

    chk_state_t      state;
    logic [TW-1:0]   tmo_cnt;
    wr_entry_t       gold_ent, got_ent, head_ent, exp_ent;
    logic            q_full, q_empty;
    logic            run, cmp_vld, cmp_ok, push_en, pop_en;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // With an empty queue the golden inputs are the expected value (bypass).
    always_comb begin
        run      = (state == CHECK);
        gold_ent = '{addr: GOLD_ADDR, data: GOLD_DATA};
        got_ent  = '{addr: DUT_ADDR, data: DUT_DATA};
        exp_ent  = q_empty ? gold_ent : head_ent;
        cmp_vld  = run && DUT_WE && (!q_empty || GOLD_WE);
        cmp_ok   = (exp_ent == got_ent);
        pop_en   = run && DUT_WE && !q_empty;
        push_en  = run && GOLD_WE && !(q_empty && DUT_WE);
    end

    wr_commit_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .clr   (CLEAR),
        .push  (push_en),
        .pop   (pop_en),
        .wdat  (gold_ent),
        .rdat  (head_ent),
        .full  (q_full),
        .empty (q_empty),
        .count (PENDING)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= CHECK;
            tmo_cnt     <= '0;
            MATCH_CNT   <= '0;
            ERR_CNT     <= '0;
            MISMATCH    <= 1'b0;
            UNEXPECTED  <= 1'b0;
            OVERFLOW    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else if (CLEAR) begin
            state       <= CHECK;
            tmo_cnt     <= '0;
            MATCH_CNT   <= '0;
            ERR_CNT     <= '0;
            MISMATCH    <= 1'b0;
            UNEXPECTED  <= 1'b0;
            OVERFLOW    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else if (run) begin
            if (cmp_vld) begin
                if (cmp_ok) begin
                    MATCH_CNT <= sat_inc(MATCH_CNT);
                end else begin
                    ERR_CNT  <= sat_inc(ERR_CNT);
                    MISMATCH <= 1'b1;
                end
            end else if (DUT_WE) begin
                ERR_CNT    <= sat_inc(ERR_CNT);
                UNEXPECTED <= 1'b1;
            end
            if (GOLD_WE && q_full && !DUT_WE) OVERFLOW <= 1'b1;
            if (DUT_WE || q_empty) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt + 1'b1 == TMO_LIM) begin
                    TIMEOUT_ERR <= 1'b1;
                    state       <= HALT;
                end
            end
        end
    end

`ifdef WR_COMMIT_CHECKER_CAPTURE_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            FAIL_ADDR_EXP <= '0;
            FAIL_ADDR_GOT <= '0;
            FAIL_DATA_EXP <= '0;
            FAIL_DATA_GOT <= '0;
            FAIL_INDEX    <= '0;
        end else if (CLEAR) begin
            FAIL_ADDR_EXP <= '0;
            FAIL_ADDR_GOT <= '0;
            FAIL_DATA_EXP <= '0;
            FAIL_DATA_GOT <= '0;
            FAIL_INDEX    <= '0;
        end else if (cmp_vld && !cmp_ok && !MISMATCH) begin
            FAIL_ADDR_EXP <= exp_ent.addr;
            FAIL_ADDR_GOT <= got_ent.addr;
            FAIL_DATA_EXP <= exp_ent.data;
            FAIL_DATA_GOT <= got_ent.data;
            FAIL_INDEX    <= MATCH_CNT + ERR_CNT;
        end
    end
`else
    // Capture registers are absent in this build.
`endif
endmodule

// File: tb/tb_wr_commit_checker.sv
// Directed bench for wr_commit_checker: streaming match, bypass, unexpected, overflow, timeout/HALT, async reset.
module tb_wr_commit_checker;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CLEAR = 1'b0;
    logic        GOLD_WE = 1'b0;
    logic [9:0]  GOLD_ADDR = '0;
    logic [31:0] GOLD_DATA = '0;
    logic        DUT_WE = 1'b0;
    logic [9:0]  DUT_ADDR = '0;
    logic [31:0] DUT_DATA = '0;
    logic [15:0] MATCH_CNT, ERR_CNT;
    logic        MISMATCH, UNEXPECTED, OVERFLOW, TIMEOUT_ERR;
    logic [3:0]  PENDING;
`ifdef WR_COMMIT_CHECKER_CAPTURE_EN
    logic [9:0]  FAIL_ADDR_EXP, FAIL_ADDR_GOT;
    logic [31:0] FAIL_DATA_EXP, FAIL_DATA_GOT;
    logic [15:0] FAIL_INDEX;
`endif

    int checks = 0;
    int errors = 0;

    wr_commit_checker #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(8), .CNT_WIDTH(16), .TIMEOUT(64)
    ) dut (
        .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR),
        .GOLD_WE(GOLD_WE), .GOLD_ADDR(GOLD_ADDR), .GOLD_DATA(GOLD_DATA),
        .DUT_WE(DUT_WE), .DUT_ADDR(DUT_ADDR), .DUT_DATA(DUT_DATA),
        .MATCH_CNT(MATCH_CNT), .ERR_CNT(ERR_CNT),
        .MISMATCH(MISMATCH), .UNEXPECTED(UNEXPECTED), .OVERFLOW(OVERFLOW),
        .TIMEOUT_ERR(TIMEOUT_ERR), .PENDING(PENDING)
`ifdef WR_COMMIT_CHECKER_CAPTURE_EN
        ,
        .FAIL_ADDR_EXP(FAIL_ADDR_EXP), .FAIL_ADDR_GOT(FAIL_ADDR_GOT),
        .FAIL_DATA_EXP(FAIL_DATA_EXP), .FAIL_DATA_GOT(FAIL_DATA_GOT),
        .FAIL_INDEX(FAIL_INDEX)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input int m, input int e, input logic mm,
                               input logic ue, input logic ov, input logic to, input int p);
        check({tag, ".match"},    32'(MATCH_CNT),   32'(m));
        check({tag, ".err"},      32'(ERR_CNT),     32'(e));
        check({tag, ".mismatch"}, 32'(MISMATCH),    32'(mm));
        check({tag, ".unexp"},    32'(UNEXPECTED),  32'(ue));
        check({tag, ".ovf"},      32'(OVERFLOW),    32'(ov));
        check({tag, ".tmo"},      32'(TIMEOUT_ERR), 32'(to));
        check({tag, ".pending"},  32'(PENDING),     32'(p));
    endtask

    // Drive one cycle of strobes, wait for the edge, then settle 1 time unit past it.
    task automatic cyc(input logic gwe, input logic [9:0] ga, input logic [31:0] gd,
                       input logic dwe, input logic [9:0] da, input logic [31:0] dd);
        GOLD_WE = gwe; GOLD_ADDR = ga; GOLD_DATA = gd;
        DUT_WE  = dwe; DUT_ADDR  = da; DUT_DATA  = dd;
        @(posedge CLK);
        #1;
        GOLD_WE = 1'b0; DUT_WE = 1'b0;
    endtask

    task automatic gw(input logic [9:0] a, input logic [31:0] d); cyc(1'b1, a, d, 1'b0, '0, '0); endtask
    task automatic dw(input logic [9:0] a, input logic [31:0] d); cyc(1'b0, '0, '0, 1'b1, a, d); endtask
    task automatic idle(); cyc(1'b0, '0, '0, 1'b0, '0, '0); endtask

    task automatic do_clear();
        CLEAR = 1'b1;
        @(posedge CLK);
        #1;
        CLEAR = 1'b0;
    endtask

    initial begin
        #3;
        check_state("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Two golden writes, DUT repeats them later in order.
        gw(10'h010, 32'h1);
        gw(10'h014, 32'h2);
        check("stream.pending2", 32'(PENDING), 32'd2);
        idle();
        dw(10'h010, 32'h1);
        check_state("stream.first", 1, 0, 0, 0, 0, 0, 1);
        dw(10'h014, 32'h2);
        check_state("stream.done", 2, 0, 0, 0, 0, 0, 0);
        do_clear();
        check_state("clear1", 0, 0, 0, 0, 0, 0, 0);

        // Bypass compare with empty queue.
        cyc(1'b1, 10'h020, 32'h5, 1'b1, 10'h020, 32'h6);
        check_state("bypass.mis", 0, 1, 1, 0, 0, 0, 0);
`ifdef WR_COMMIT_CHECKER_CAPTURE_EN
        check("cap.dexp", FAIL_DATA_EXP, 32'h5);
        check("cap.dgot", FAIL_DATA_GOT, 32'h6);
        check("cap.aexp", 32'(FAIL_ADDR_EXP), 32'h020);
        check("cap.idx",  32'(FAIL_INDEX), 32'd0);
`endif
        cyc(1'b1, 10'h030, 32'h7, 1'b1, 10'h030, 32'h7);
        check_state("bypass.match", 1, 1, 1, 0, 0, 0, 0);
        cyc(1'b1, 10'h040, 32'h8, 1'b1, 10'h044, 32'h8);
        check_state("bypass.addrmis", 1, 2, 1, 0, 0, 0, 0);
`ifdef WR_COMMIT_CHECKER_CAPTURE_EN
        check("cap.first_only", FAIL_DATA_GOT, 32'h6);
`endif
        do_clear();
`ifdef WR_COMMIT_CHECKER_CAPTURE_EN
        check("cap.cleared", FAIL_DATA_EXP, 32'h0);
`endif

        // DUT write with nothing queued.
        dw(10'h050, 32'h9);
        check_state("unexpected", 0, 1, 0, 1, 0, 0, 0);
        do_clear();

        // Fill to DEPTH, overflow on the 9th, then drain in order.
        for (int i = 0; i < 8; i++) gw(10'(10'h100 + 4*i), 32'hA0 + i);
        check_state("fill8", 0, 0, 0, 0, 0, 0, 8);
        gw(10'h3FC, 32'hDEAD);
        check_state("overflow", 0, 0, 0, 0, 1, 0, 8);
        for (int i = 0; i < 8; i++) dw(10'(10'h100 + 4*i), 32'hA0 + i);
        check_state("drain8", 8, 0, 0, 0, 1, 0, 0);
        do_clear();

        // Push and pop together while full: occupancy holds, new entry lands at the tail.
        for (int i = 0; i < 8; i++) gw(10'(10'h100 + 4*i), 32'hA0 + i);
        cyc(1'b1, 10'h200, 32'hBB, 1'b1, 10'h100, 32'hA0);
        check_state("full.pushpop", 1, 0, 0, 0, 0, 0, 8);
        for (int i = 1; i < 8; i++) dw(10'(10'h100 + 4*i), 32'hA0 + i);
        dw(10'h200, 32'hBB);
        check_state("full.drain", 9, 0, 0, 0, 0, 0, 0);
        do_clear();

        // Commit timeout after 64 idle cycles with a pending entry.
        gw(10'h300, 32'h33);
        repeat (63) idle();
        check("tmo.before", 32'(TIMEOUT_ERR), 32'd0);
        idle();
        check("tmo.hit", 32'(TIMEOUT_ERR), 32'd1);
        dw(10'h300, 32'h33);
        gw(10'h304, 32'h34);
        check_state("halt.frozen", 0, 0, 0, 0, 0, 1, 1);
        do_clear();
        check_state("halt.clear", 0, 0, 0, 0, 0, 0, 0);
        cyc(1'b1, 10'h308, 32'h35, 1'b1, 10'h308, 32'h35);
        check("resume.match", 32'(MATCH_CNT), 32'd1);

        // Asynchronous reset between edges discards queued entries.
        gw(10'h010, 32'h1);
        gw(10'h014, 32'h2);
        gw(10'h018, 32'h3);
        check("prereset.pending", 32'(PENDING), 32'd3);
        RESET = 1'b1;
        #2;
        check_state("async.reset", 0, 0, 0, 0, 0, 0, 0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        dw(10'h010, 32'h1);
        check_state("after.reset", 0, 1, 0, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
